// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between fetch (i_*) and load/store (d_*) with one transaction in flight.
// Latency: accept in IDLE -> mem_req next cycle -> response routed combinationally on mem_valid in WAIT (min 2 cycles).
// Backpressure: requesters hold req/fields until their rdy; mem_req/mem_* held stable until mem_rdy.
// Ports: clk/rst (sync, active-high); fetch i_req/i_addr -> i_rdy/i_valid/i_rdata;
//        data d_req/d_we/d_be/d_addr/d_wdata -> d_rdy/d_valid/d_rdata;
//        memory mem_req/mem_we/mem_be/mem_addr/mem_wdata <- mem_rdy/mem_valid/mem_rdata; busy = not IDLE.
module mem_port_arbiter #(
  parameter int bits       = 32,
  parameter int MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [bits-1:0]   i_addr,
  output logic              i_rdy,
  output logic              i_valid,
  output logic [bits-1:0]   i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [bits/8-1:0] d_be,
  input  logic [bits-1:0]   d_addr,
  input  logic [bits-1:0]   d_wdata,
  output logic              d_rdy,
  output logic              d_valid,
  output logic [bits-1:0]   d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [bits/8-1:0] mem_be,
  output logic [bits-1:0]   mem_addr,
  output logic [bits-1:0]   mem_wdata,
  input  logic              mem_rdy,
  input  logic              mem_valid,
  input  logic [bits-1:0]   mem_rdata,
  output logic              busy
);

  localparam int CW = $clog2(MAX_CONSEC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CONSEC);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state;
  logic              owner_d;   // 1 = load/store owns the transaction, 0 = fetch
  logic              we_q;
  logic [bits/8-1:0] be_q;
  logic [bits-1:0]   addr_q;
  logic [bits-1:0]   wdata_q;
  logic [CW-1:0]     cnt;       // consecutive data grants while fetch waits

  logic starve;
  logic grant_d;
  logic grant_i;
  logic resp;

  // Data normally wins; once fetch has been passed over MAX_CONSEC times, it wins.
  assign starve  = i_req && (cnt == CNT_MAX);
  assign grant_d = (state == IDLE) && d_req && !starve;
  assign grant_i = (state == IDLE) && i_req && !grant_d;

  assign i_rdy = grant_i;
  assign d_rdy = grant_d;

  // Responses are only meaningful in WAIT; stray mem_valid elsewhere is dropped.
  assign resp    = (state == WAIT) && mem_valid;
  assign d_valid = resp && owner_d;
  assign i_valid = resp && !owner_d;

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  assign mem_req   = (state == ISSUE);
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state   <= ISSUE;
            owner_d <= 1'b1;
            we_q    <= d_we;
            be_q    <= d_be;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            if (i_req && (cnt != CNT_MAX)) cnt <= cnt + 1'b1;
          end else if (grant_i) begin
            state   <= ISSUE;
            owner_d <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '1;
            addr_q  <= i_addr;
            wdata_q <= '0;
            cnt     <= '0;
          end
        end
        ISSUE: begin
          if (mem_rdy) state <= WAIT;
        end
        WAIT: begin
          if (mem_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_rdy, i_valid;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_rdy, d_valid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rdy, mem_valid;
  logic [31:0] mem_rdata;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.bits(32), .MAX_CONSEC(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdy(d_rdy), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdy(mem_rdy), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_rdy = 0; mem_valid = 0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    nxt(); nxt();
    rst = 0;
    #4;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    vectors++; if ({i_rdy, d_rdy, i_valid, d_valid} !== 4'b0) begin miscompares++; $display("FAIL reset_handshake got %b exp 0000", {i_rdy, d_rdy, i_valid, d_valid}); end
    vectors++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== 69'd0) begin miscompares++; $display("FAIL reset_latched got %h exp 0", {mem_we, mem_be, mem_addr, mem_wdata}); end
    nxt();
  endtask

  task automatic test_fetch();
    i_req = 1; i_addr = 32'h100; mem_rdy = 1;
    #4;
    vectors++; if ({i_rdy, d_rdy} !== 2'b10) begin miscompares++; $display("FAIL fetch_rdy got %b exp 10", {i_rdy, d_rdy}); end
    nxt();
    i_req = 0; i_addr = 32'h999;
    #4;
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL fetch_mem_req got %b exp 1", mem_req); end
    vectors++; if (mem_addr !== 32'h100) begin miscompares++; $display("FAIL fetch_mem_addr got %h exp 00000100", mem_addr); end
    vectors++; if ({mem_we, mem_be} !== 5'b0_1111) begin miscompares++; $display("FAIL fetch_we_be got %b exp 01111", {mem_we, mem_be}); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL fetch_busy_issue got %b exp 1", busy); end
    nxt();
    mem_rdy = 0; mem_valid = 1; mem_rdata = 32'h00500093;
    #4;
    vectors++; if ({i_valid, d_valid} !== 2'b10) begin miscompares++; $display("FAIL fetch_valid got %b exp 10", {i_valid, d_valid}); end
    vectors++; if (i_rdata !== 32'h00500093) begin miscompares++; $display("FAIL fetch_rdata got %h exp 00500093", i_rdata); end
    vectors++; if ({mem_req, busy} !== 2'b01) begin miscompares++; $display("FAIL fetch_wait_req_busy got %b exp 01", {mem_req, busy}); end
    nxt();
    mem_valid = 0;
    #4;
    vectors++; if ({busy, i_valid} !== 2'b00) begin miscompares++; $display("FAIL fetch_done got %b exp 00", {busy, i_valid}); end
    nxt();
  endtask

  task automatic test_slow_write();
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; mem_rdy = 0;
    #4;
    vectors++; if ({i_rdy, d_rdy} !== 2'b01) begin miscompares++; $display("FAIL slow_rdy got %b exp 01", {i_rdy, d_rdy}); end
    nxt();
    d_req = 0; d_addr = 32'h55; d_wdata = 32'h0;
    for (int c = 0; c < 4; c++) begin
      mem_rdy = (c == 3);
      #4;
      vectors++; if ({mem_req, mem_we, mem_be} !== 6'b11_1111) begin miscompares++; $display("FAIL slow_req_we_be cyc %0d got %b exp 111111", c, {mem_req, mem_we, mem_be}); end
      vectors++; if ({mem_addr, mem_wdata} !== {32'h200, 32'hDEADBEEF}) begin miscompares++; $display("FAIL slow_addr_wdata cyc %0d got %h exp 00000200deadbeef", c, {mem_addr, mem_wdata}); end
      nxt();
    end
    mem_rdy = 0;
    #4;
    vectors++; if ({mem_req, d_valid, busy} !== 3'b001) begin miscompares++; $display("FAIL slow_wait_idle got %b exp 001", {mem_req, d_valid, busy}); end
    nxt();
    mem_valid = 1; mem_rdata = 32'h12345678;
    #4;
    vectors++; if ({i_valid, d_valid} !== 2'b01) begin miscompares++; $display("FAIL slow_valid got %b exp 01", {i_valid, d_valid}); end
    nxt();
    mem_valid = 0;
    #4;
    vectors++; if ({d_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL slow_done got %b exp 00", {d_valid, busy}); end
    nxt();
  endtask

  task automatic test_simultaneous();
    i_req = 1; i_addr = 32'h180; d_req = 1; d_we = 0; d_be = 4'h3; d_addr = 32'h280; mem_rdy = 1;
    #4;
    vectors++; if ({i_rdy, d_rdy} !== 2'b01) begin miscompares++; $display("FAIL simul_rdy got %b exp 01", {i_rdy, d_rdy}); end
    nxt();
    d_req = 0;
    #4;
    vectors++; if ({i_rdy, mem_addr, mem_be} !== {1'b0, 32'h280, 4'h3}) begin miscompares++; $display("FAIL simul_issue got %h exp 0000002803", {i_rdy, mem_addr, mem_be}); end
    nxt();
    mem_valid = 1;
    #4;
    vectors++; if ({i_valid, d_valid, i_rdy} !== 3'b010) begin miscompares++; $display("FAIL simul_dvalid got %b exp 010", {i_valid, d_valid, i_rdy}); end
    nxt();
    mem_valid = 0;
    #4;
    vectors++; if ({i_rdy, d_rdy} !== 2'b10) begin miscompares++; $display("FAIL simul_fetch_next got %b exp 10", {i_rdy, d_rdy}); end
    nxt();
    i_req = 0;
    #4;
    vectors++; if (mem_addr !== 32'h180) begin miscompares++; $display("FAIL simul_fetch_addr got %h exp 00000180", mem_addr); end
    nxt();
    mem_valid = 1;
    #4;
    vectors++; if ({i_valid, d_valid} !== 2'b10) begin miscompares++; $display("FAIL simul_ivalid got %b exp 10", {i_valid, d_valid}); end
    nxt();
    clear_inputs();
  endtask

  task automatic test_starvation();
    logic exp_d [10];
    exp_d = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    i_req = 1; i_addr = 32'h500; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h600; mem_rdy = 1;
    for (int g = 0; g < 10; g++) begin
      mem_valid = 0;
      #4;
      vectors++; if ({i_rdy, d_rdy} !== {!exp_d[g], exp_d[g]}) begin miscompares++; $display("FAIL starve_grant %0d got %b exp %b", g, {i_rdy, d_rdy}, {!exp_d[g], exp_d[g]}); end
      nxt();
      #4;
      vectors++; if (mem_addr !== (exp_d[g] ? 32'h600 : 32'h500)) begin miscompares++; $display("FAIL starve_addr %0d got %h exp %h", g, mem_addr, exp_d[g] ? 32'h600 : 32'h500); end
      nxt();
      mem_valid = 1;
      #4;
      vectors++; if ({i_valid, d_valid} !== {!exp_d[g], exp_d[g]}) begin miscompares++; $display("FAIL starve_valid %0d got %b exp %b", g, {i_valid, d_valid}, {!exp_d[g], exp_d[g]}); end
      nxt();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    d_req = 1; d_addr = 32'h300; d_be = 4'hF; mem_rdy = 1;
    nxt();
    d_req = 0;
    nxt();
    mem_rdy = 0;
    #4;
    vectors++; if ({busy, mem_req} !== 2'b10) begin miscompares++; $display("FAIL rstmid_in_wait got %b exp 10", {busy, mem_req}); end
    nxt();
    rst = 1;
    nxt();
    rst = 0; mem_valid = 1; mem_rdata = 32'hA5A5A5A5;
    #4;
    vectors++; if ({i_valid, d_valid, busy, mem_req, i_rdy, d_rdy} !== 6'b0) begin miscompares++; $display("FAIL rstmid_outputs got %b exp 000000", {i_valid, d_valid, busy, mem_req, i_rdy, d_rdy}); end
    vectors++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== 69'd0) begin miscompares++; $display("FAIL rstmid_latched got %h exp 0", {mem_we, mem_be, mem_addr, mem_wdata}); end
    nxt();
    mem_valid = 0;
    #4;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_still_idle got %b exp 0", busy); end
    nxt();
  endtask

  task automatic test_spurious();
    mem_valid = 1;
    #4;
    vectors++; if ({i_valid, d_valid, i_rdy, d_rdy, busy} !== 5'b0) begin miscompares++; $display("FAIL spur_idle got %b exp 00000", {i_valid, d_valid, i_rdy, d_rdy, busy}); end
    nxt();
    mem_valid = 0; i_req = 1; i_addr = 32'h400; mem_rdy = 0;
    nxt();
    i_req = 0; mem_valid = 1;
    #4;
    vectors++; if ({i_valid, d_valid, mem_req} !== 3'b001) begin miscompares++; $display("FAIL spur_issue got %b exp 001", {i_valid, d_valid, mem_req}); end
    nxt();
    mem_rdy = 1;
    #4;
    vectors++; if ({i_valid, d_valid, mem_req} !== 3'b001) begin miscompares++; $display("FAIL spur_issue_rdy got %b exp 001", {i_valid, d_valid, mem_req}); end
    nxt();
    mem_rdy = 0; mem_valid = 0;
    #4;
    vectors++; if ({i_valid, d_valid, busy} !== 3'b001) begin miscompares++; $display("FAIL spur_wait_quiet got %b exp 001", {i_valid, d_valid, busy}); end
    nxt();
    mem_valid = 1; mem_rdata = 32'hCAFEF00D;
    #4;
    vectors++; if ({i_valid, d_valid} !== 2'b10) begin miscompares++; $display("FAIL spur_real_valid got %b exp 10", {i_valid, d_valid}); end
    vectors++; if (i_rdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL spur_rdata got %h exp cafef00d", i_rdata); end
    nxt();
    #4;
    vectors++; if ({i_valid, d_valid, busy} !== 3'b000) begin miscompares++; $display("FAIL spur_once got %b exp 000", {i_valid, d_valid, busy}); end
    nxt();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_slow_write();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_spurious();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
